// File: rtl/fir_rns_system.sv
// FIR filter computed in a four-channel residue number system.
// Samples are converted to residues on load, and results are CRT-reconstructed on read.
module fir_rns_system #(
  parameter int N_TAPS       = 10,
  parameter int SIGNAL_COUNT = 10,
  parameter int M1           = 233,
  parameter int M2           = 239,
  parameter int M3           = 241,
  parameter int M4           = 251
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] x,
  input  logic [1:0]  operation,
  output logic [31:0] y,
  output logic        done
);

  localparam int IW = $clog2(SIGNAL_COUNT + 1);
  localparam int KW = $clog2(N_TAPS + 1);
  localparam logic [63:0] MM = 64'(M1) * 64'(M2) * 64'(M3) * 64'(M4);
  localparam logic [31:0] MOD32 [4] = '{32'(M1), 32'(M2), 32'(M3), 32'(M4)};

  localparam logic [1:0] OP_LOAD    = 2'b01;
  localparam logic [1:0] OP_COMPUTE = 2'b10;

  // CRT weight for one channel: (M/Mi) * inverse(M/Mi mod Mi), reduced mod M.
  function automatic logic [63:0] crt_coef(input logic [63:0] mi);
    logic [63:0] mhat;
    logic [63:0] inv;
    mhat = MM / mi;
    inv  = 64'd0;
    for (int t = 1; t < 256; t++) begin
      if (64'(t) < mi && (((mhat % mi) * 64'(t)) % mi) == 64'd1) inv = 64'(t);
    end
    return (mhat * inv) % MM;
  endfunction

  localparam logic [63:0] C1 = crt_coef(64'(M1));
  localparam logic [63:0] C2 = crt_coef(64'(M2));
  localparam logic [63:0] C3 = crt_coef(64'(M3));
  localparam logic [63:0] C4 = crt_coef(64'(M4));

  function automatic logic [31:0] to_rns(input logic [31:0] v);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(v % MOD32[j]);
    return r;
  endfunction

  // One channel MAC: (acc + h[k]*s) mod m, with h[k] = k+1 taken as a residue.
  function automatic logic [7:0] mac_ch(input logic [7:0] a, input logic [31:0] kk,
                                        input logic [7:0] s, input logic [31:0] m);
    logic [31:0] h;
    h = (kk + 32'd1) % m;
    return 8'((32'(a) + h * 32'(s)) % m);
  endfunction

  logic [31:0]   s_q      [SIGNAL_COUNT];
  logic [31:0]   s_d      [SIGNAL_COUNT];
  logic [31:0]   result_q [SIGNAL_COUNT];
  logic [31:0]   result_d [SIGNAL_COUNT];
  logic [IW-1:0] i_q, i_d;
  logic [KW-1:0] k_q, k_d;
  logic [31:0]   acc_q, acc_d;
  logic          done_q, done_d;

  logic          addr_ok;
  logic [IW-1:0] addr_idx;
  logic [IW-1:0] s_idx;
  logic [31:0]   s_sel;
  logic [31:0]   mac_acc;
  logic [31:0]   r_sel;
  logic [63:0]   crt_sum;

  assign addr_ok  = addr < 32'(SIGNAL_COUNT);
  assign addr_idx = addr[IW-1:0];
  assign s_idx    = IW'(32'(i_q) - 32'(k_q));

  always_comb begin
    s_sel = '0;
    if (32'(i_q) < 32'(SIGNAL_COUNT) && 32'(i_q) >= 32'(k_q)) s_sel = s_q[s_idx];
    for (int j = 0; j < 4; j++) begin
      mac_acc[8*j +: 8] = mac_ch(acc_q[8*j +: 8], 32'(k_q), s_sel[8*j +: 8], MOD32[j]);
    end
  end

  always_comb begin
    s_d      = s_q;
    result_d = result_q;
    i_d      = i_q;
    k_d      = k_q;
    acc_d    = acc_q;
    done_d   = done_q;
    case (operation)
      OP_LOAD: begin
        if (addr_ok) s_d[addr_idx] = to_rns(x);
        done_d = 1'b0;
        i_d    = '0;
        k_d    = '0;
        acc_d  = '0;
      end
      OP_COMPUTE: begin
        if (!done_q) begin
          // i_q == SIGNAL_COUNT marks the extra cycle that follows the last MAC.
          if (32'(i_q) == 32'(SIGNAL_COUNT)) begin
            done_d = 1'b1;
          end else if (32'(k_q) == 32'(N_TAPS - 1)) begin
            result_d[i_q] = mac_acc;
            acc_d         = '0;
            k_d           = '0;
            i_d           = i_q + 1'b1;
          end else begin
            acc_d = mac_acc;
            k_d   = k_q + 1'b1;
          end
        end
      end
      default: begin
        i_d   = '0;
        k_d   = '0;
        acc_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s_q      <= '{default: '0};
      result_q <= '{default: '0};
      i_q      <= '0;
      k_q      <= '0;
      acc_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      s_q      <= s_d;
      result_q <= result_d;
      i_q      <= i_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    r_sel   = '0;
    crt_sum = '0;
    y       = '0;
    if (addr_ok) begin
      r_sel   = result_q[addr_idx];
      crt_sum = 64'(r_sel[7:0]) * C1 + 64'(r_sel[15:8]) * C2 +
                64'(r_sel[23:16]) * C3 + 64'(r_sel[31:24]) * C4;
      y       = 32'(crt_sum % MM);
    end
  end

  assign done = done_q;

endmodule

// File: tb/tb_fir_rns_system.sv
// Directed-plus-random bench for fir_rns_system against a plain-integer convolution model.
module tb_fir_rns_system;

  localparam int NT = 10;
  localparam int SC = 10;
  localparam longint unsigned MM = 64'd233 * 64'd239 * 64'd241 * 64'd251;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] x = '0;
  logic [1:0]  operation = 2'b00;
  logic [31:0] y;
  logic        done;

  int n_cmp = 0;
  int n_err = 0;
  longint unsigned xm [SC];

  fir_rns_system dut (
    .clk(clk), .reset(reset), .addr(addr), .x(x),
    .operation(operation), .y(y), .done(done)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Direct convolution y[i] = sum (k+1)*x[i-k], reduced mod M at the end.
  function automatic logic [31:0] ref_y(input int i);
    longint unsigned acc;
    acc = 0;
    for (int k = 0; k < NT; k++) begin
      if (i - k >= 0) acc += longint'(k + 1) * xm[i - k];
    end
    return 32'(acc % MM);
  endfunction

  task automatic load(input logic [31:0] a, input logic [31:0] v);
    addr = a;
    x = v;
    operation = 2'b01;
    cyc();
    operation = 2'b00;
    if (a < SC) xm[a] = longint'(v);
  endtask

  task automatic compute(input string tag);
    int cycles;
    operation = 2'b10;
    cycles = 0;
    while (cycles < 400) begin
      cyc();
      cycles++;
      if (done === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(cycles), 32'd101);
    repeat (4) cyc();
    check({tag, "_done_hold"}, {31'b0, done}, 32'd1);
    operation = 2'b00;
  endtask

  task automatic check_results(input string tag);
    operation = 2'b11;
    for (int i = 0; i < SC; i++) begin
      addr = i;
      #1;
      check($sformatf("%s_y%0d", tag, i), y, ref_y(i));
    end
    operation = 2'b00;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    for (int i = 0; i <= SC; i++) begin
      addr = i;
      #1;
      check($sformatf("%s_y%0d", tag, i), y, 32'd0);
    end
    addr = 32'hFFFF_FFFF;
    #1;
    check({tag, "_yffff"}, y, 32'd0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) cyc();
    reset = 1'b0;
    for (int i = 0; i < SC; i++) xm[i] = 0;
  endtask

  logic [31:0] exp_basic [SC];

  initial begin
    int cycles;
    exp_basic = '{32'd0, 32'd1, 32'd4, 32'd10, 32'd20, 32'd35, 32'd56, 32'd84, 32'd120, 32'd165};
    @(negedge clk);
    do_reset();
    check_zero("reset");

    for (int i = 0; i < SC; i++) load(i, i);
    load(10, 0);
    compute("basic");
    check_results("basic");
    operation = 2'b11;
    for (int i = 0; i < SC; i++) begin
      addr = i;
      #1;
      check($sformatf("basic_const_y%0d", i), y, exp_basic[i]);
    end

    addr = 10;
    #1;
    check("read_addr10", y, 32'd0);
    addr = 32'hFFFF_FFFF;
    #1;
    check("read_addr_max", y, 32'd0);
    load(12, 32'd12345);
    check("load_oob_clears_done", {31'b0, done}, 32'd0);
    check_results("oob_hold");
    compute("oob_recompute");
    check_results("oob_recompute");

    load(0, 32'd3368562318);
    for (int i = 1; i < SC; i++) load(i, 0);
    compute("mplus1");
    operation = 2'b11;
    addr = 0; #1; check("mplus1_y0", y, 32'd1);
    addr = 1; #1; check("mplus1_y1", y, 32'd2);
    addr = 9; #1; check("mplus1_y9", y, 32'd10);
    check_results("mplus1");

    for (int i = 0; i < SC; i++) load(i, i);
    operation = 2'b10;
    repeat (50) cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    operation = 2'b00;
    for (int i = 0; i < SC; i++) xm[i] = 0;
    cyc();
    check_zero("midreset");
    for (int i = 0; i < SC; i++) load(i, i);
    compute("after_reset");
    check_results("after_reset");

    for (int i = 0; i < SC; i++) load(i, $urandom_range(0, 1000));
    operation = 2'b10;
    repeat (30) cyc();
    operation = 2'b00;
    repeat (5) cyc();
    check("abort_done", {31'b0, done}, 32'd0);
    compute("abort_restart");
    check_results("abort_restart");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < SC; i++) load(i, $urandom());
      compute($sformatf("rand%0d", r));
      check_results($sformatf("rand%0d", r));
      operation = 2'b11;
      repeat (3) cyc();
      check($sformatf("rand%0d_read_done", r), {31'b0, done}, 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fir_rns_system.md
FIR_RNS_SYSTEM -- requirements
Module: fir_rns_system

Interface
REQ-001 The module SHALL have parameter N_TAPS, default 10, meaning the number of FIR taps.
REQ-002 The module SHALL have parameter SIGNAL_COUNT, default 10, meaning the number of input samples and output results.
REQ-003 The module SHALL have parameters M1, M2, M3, M4, defaults 233, 239, 241, 251, meaning pairwise-coprime RNS moduli.
REQ-004 clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 addr  input  32  sample write index (operation 01) or result read index (operation 11).
REQ-007 x  input  32  unsigned integer sample to store.
REQ-008 operation  input  2  command: 00 idle, 01 load, 10 compute, 11 read.
REQ-009 y  output  32  unsigned integer result read back.
REQ-010 done  output  1  computation complete flag.

Function
REQ-011 Forward conversion SHALL be combinational: residue r_i = x mod M_i, packed as bits [7:0]=M1, [15:8]=M2, [23:16]=M3, [31:24]=M4.
REQ-012 Reverse conversion SHALL be combinational CRT: y = (sum r_i * (M/M_i) * inv_i) mod M, where M = M1*M2*M3*M4 (3,368,562,317 for the defaults), and inv_i is the inverse of M/M_i mod M_i, computed with intermediates wide enough to avoid overflow.
REQ-013 All values SHALL be unsigned; the FIR result SHALL be exact mod M.
REQ-014 Coefficients SHALL be fixed h[k] = k+1 for k = 0..N_TAPS-1, stored as residues per channel.
REQ-015 Operation 01 SHALL write the converted residues of x into sample memory s[addr] on the clock edge when addr < SIGNAL_COUNT; writes with addr >= SIGNAL_COUNT SHALL be ignored.
REQ-016 Operation 01 SHALL clear done and the computation counters.
REQ-017 Operation 10 with done=0 SHALL perform one residue multiply-accumulate per cycle, per channel in parallel.
REQ-018 MAC order SHALL be output index i = 0..SIGNAL_COUNT-1 outer and k = 0..N_TAPS-1 inner.
REQ-019 Each MAC SHALL compute acc = (acc + h[k]*s[i-k]) mod M_j, with terms where i-k < 0 contributing 0.
REQ-020 At k = N_TAPS-1, acc plus the final term SHALL be stored to result[i], and acc SHALL be cleared for the next i.
REQ-021 done SHALL be a registered output that rises on the edge after the last MAC, SIGNAL_COUNT*N_TAPS+1 cycles after operation 10 is first sampled.
REQ-022 Once done=1, further operation 10 cycles SHALL hold all state.
REQ-023 If operation leaves 10 before completion, the counters and acc SHALL reset, done SHALL remain 0, and a later operation 10 SHALL restart from i=0.
REQ-024 Operations 00 and 11 SHALL hold sample memory, results, and done.
REQ-025 y SHALL be combinational: the reverse conversion of result[addr] when addr < SIGNAL_COUNT, else 0, independent of operation.

Reset
REQ-026 On reset, done SHALL be 0, counters and acc SHALL be 0, and all sample and result memories SHALL be cleared to 0, so y=0.
REQ-027 Reset SHALL take priority over any operation, including a computation in progress.

Verification
REQ-028 Reset, then sample done and y -> done=0, y=0 for every addr.
REQ-029 Load s = 0..9 at addr 0..9 (addr 10 with x=0 also driven), operation 10 -> done rises exactly 101 cycles later; reading addr 0..9 gives y = 0, 1, 4, 10, 20, 35, 56, 84, 120, 165.
REQ-030 x = 3,368,562,318 (M+1) loaded at addr 0, others 0, compute -> y[0]=1, y[1]=2, y[9]=10.
REQ-031 Assert reset at cycle 50 of a computation -> done=0 and y=0; a reload and compute then yields the values of REQ-029.
REQ-032 Switch operation 10->00 mid-computation, then back to 10 -> done requires a full 101 cycles; results are correct.
REQ-033 Read with addr=10 or addr=0xFFFFFFFF after done -> y=0; load with addr=12 -> memory unchanged.
